// File: rtl/tz80_bus_target.sv
// tz80_bus_target: CPU bus target that puts an async SRAM and a small internal
// I/O page (LED register, free-running timer with a latched high byte) behind
// a locked/advance handshake.
// Latency: I/O page accesses complete in the same cycle (zero wait).
//          SRAM accesses take WAIT+3 cycles: IDLE, WAIT+1 RUN cycles, then HOLD.
// Backpressure: locked=0 stalls the CPU, which holds address/we/o_data steady
//          until locked=1.
// Ports:
//   clock, resetn      rising-edge clock, synchronous active-low reset
//   address, o_data,   CPU address, write data and write strobe
//   we
//   i_data, locked     CPU read data (0xFF unless locked) and advance enable
//   sram_a, sram_d_o,  registered SRAM address, write data and strobes
//   sram_we_n,
//   sram_oe_n
//   sram_d_i           SRAM read data
//   leds               LED port register
module tz80_bus_target #(
  parameter int unsigned WAIT    = 2,
  parameter logic [7:0]  IO_PAGE = 8'hFF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  o_data,
  input  logic        we,
  output logic [7:0]  i_data,
  output logic        locked,
  output logic [15:0] sram_a,
  output logic [7:0]  sram_d_o,
  input  logic [7:0]  sram_d_i,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [7:0]  leds
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] sram_a_q;
  logic [7:0]  sram_d_o_q;
  logic        sram_we_n_q;
  logic        sram_oe_n_q;
  logic [7:0]  rdata_q;
  logic [7:0]  leds_q;
  logic [15:0] timer_q;
  logic [7:0]  hi_latch_q;

  logic        io_hit;
  logic        idle_eff;
  logic        io_acc;
  logic [7:0]  io_rdata;

  assign io_hit = (address[15:8] == IO_PAGE);

  // While reset is held the outputs behave as if in IDLE, even during the
  // single cycle before the synchronous reset has pulled state_q back.
  assign idle_eff = (state_q == IDLE) || !resetn;

  // An I/O access completes (and may have side effects) only on an edge
  // where locked=1 and reset is not being applied.
  assign io_acc = resetn && (state_q == IDLE) && io_hit;

  always_comb begin
    io_rdata = 8'hFF;
    case (address[7:0])
      8'h00:   io_rdata = leds_q;
      8'h01:   io_rdata = timer_q[7:0];
      8'h02:   io_rdata = hi_latch_q;
      default: io_rdata = 8'hFF;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!io_hit) state_d = RUN;
      RUN:     if (cnt_q == 4'd0) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    locked = 1'b0;
    i_data = 8'hFF;
    if (idle_eff) begin
      if (io_hit) begin
        locked = 1'b1;
        i_data = io_rdata;
      end
    end else if (state_q == HOLD) begin
      locked = 1'b1;
      i_data = rdata_q;
    end
  end

  // SRAM datapath, wait counter and I/O registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q       <= 4'd0;
      sram_a_q    <= 16'h0000;
      sram_d_o_q  <= 8'h00;
      sram_we_n_q <= 1'b1;
      sram_oe_n_q <= 1'b1;
      rdata_q     <= 8'h00;
      leds_q      <= 8'h00;
      timer_q     <= 16'h0000;
      hi_latch_q  <= 8'h00;
    end else begin
      timer_q <= timer_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (!io_hit) begin
            // Address, data and direction are frozen here so the SRAM sees
            // stable values for the whole RUN phase.
            sram_a_q    <= address;
            sram_d_o_q  <= o_data;
            sram_we_n_q <= ~we;
            sram_oe_n_q <= we;
            cnt_q       <= WAIT_CNT;
          end
        end
        RUN: begin
          if (cnt_q == 4'd0) begin
            rdata_q     <= sram_d_i;
            sram_we_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase

      if (io_acc) begin
        if (we && (address[7:0] == 8'h00)) begin
          leds_q <= o_data;
        end
        // Reading the low byte freezes the high byte so a following read of
        // xx02 yields a consistent 16-bit value.
        if (!we && (address[7:0] == 8'h01)) begin
          hi_latch_q <= timer_q[15:8];
        end
      end
    end
  end

  assign sram_a    = sram_a_q;
  assign sram_d_o  = sram_d_o_q;
  assign sram_we_n = sram_we_n_q;
  assign sram_oe_n = sram_oe_n_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_tz80_bus_target.sv
// tb_tz80_bus_target: scoreboard bench for tz80_bus_target, with one instance
// at WAIT=2 and one at WAIT=0, each backed by its own async SRAM model.
// Expected results are queued when an access is issued and popped on completion.
module tb_tz80_bus_target;

  logic        clock;
  logic        resetn;

  // WAIT=2 instance
  logic [15:0] addr2;
  logic [7:0]  od2;
  logic        we2;
  logic [7:0]  id2;
  logic        locked2;
  logic [15:0] sa2;
  logic [7:0]  sdo2;
  logic [7:0]  sdi2;
  logic        swe2;
  logic        soe2;
  logic [7:0]  leds2;

  // WAIT=0 instance
  logic [15:0] addr0;
  logic [7:0]  od0;
  logic        we0;
  logic [7:0]  id0;
  logic        locked0;
  logic [15:0] sa0;
  logic [7:0]  sdo0;
  logic [7:0]  sdi0;
  logic        swe0;
  logic        soe0;
  logic [7:0]  leds0;

  tz80_bus_target #(.WAIT(2), .IO_PAGE(8'hFF)) dut (
    .clock(clock), .resetn(resetn), .address(addr2), .o_data(od2), .we(we2),
    .i_data(id2), .locked(locked2), .sram_a(sa2), .sram_d_o(sdo2),
    .sram_d_i(sdi2), .sram_we_n(swe2), .sram_oe_n(soe2), .leds(leds2)
  );

  tz80_bus_target #(.WAIT(0), .IO_PAGE(8'hFF)) dut0 (
    .clock(clock), .resetn(resetn), .address(addr0), .o_data(od0), .we(we0),
    .i_data(id0), .locked(locked0), .sram_a(sa0), .sram_d_o(sdo0),
    .sram_d_i(sdi0), .sram_we_n(swe0), .sram_oe_n(soe0), .leds(leds0)
  );

  // Async SRAM models
  logic [7:0] mem2 [0:65535];
  logic [7:0] mem0 [0:65535];
  assign sdi2 = mem2[sa2];
  assign sdi0 = mem0[sa0];
  always @(posedge clock) begin
    if (!swe2) mem2[sa2] <= sdo2;
    if (!swe0) mem0[sa0] <= sdo0;
  end

  // Reference free-running timer
  logic [15:0] tb_timer;
  always @(posedge clock) begin
    if (!resetn) tb_timer <= 16'h0000;
    else         tb_timer <= tb_timer + 16'd1;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observation mux onto whichever instance is being exercised
  bit          tb_sel;
  logic        m_locked, m_oe_n, m_we_n;
  logic [7:0]  m_i_data, m_d_o;
  logic [15:0] m_a;
  assign m_locked = tb_sel ? locked0 : locked2;
  assign m_oe_n   = tb_sel ? soe0 : soe2;
  assign m_we_n   = tb_sel ? swe0 : swe2;
  assign m_i_data = tb_sel ? id0 : id2;
  assign m_d_o    = tb_sel ? sdo0 : sdo2;
  assign m_a      = tb_sel ? sa0 : sa2;

  typedef struct {
    bit         chk_data;
    logic [7:0] data;
    int         cycles;
    int         oe_lo;
    int         we_lo;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] IDLE_ADDR = 16'hFF03;

  // Presents one access in the current cycle and waits for locked. Returns
  // observations only; callers compare against their queued expectations.
  task automatic bus_access(input bit sel, input logic [15:0] a, input bit w,
                            input logic [7:0] d, output int cyc,
                            output logic [7:0] rd, output int oe_lo,
                            output int we_lo, output bit stable,
                            output bit ff_ok);
    bit done;
    tb_sel = sel;
    if (sel) begin addr0 = a; we0 = w; od0 = d; end
    else     begin addr2 = a; we2 = w; od2 = d; end
    cyc = 0; rd = 8'h00; oe_lo = 0; we_lo = 0; stable = 1'b1; ff_ok = 1'b1;
    done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clock);
      cyc++;
      if (!m_oe_n) oe_lo++;
      if (!m_we_n) we_lo++;
      if ((!m_oe_n || !m_we_n) && (m_a !== a || (w && m_d_o !== d))) stable = 1'b0;
      if (m_locked === 1'b1) begin
        done = 1'b1;
        rd   = m_i_data;
      end else if (m_i_data !== 8'hFF) begin
        ff_ok = 1'b0;
      end
    end
    if (!done) cyc = -1;
    @(posedge clock); #1;
    if (sel) begin addr0 = IDLE_ADDR; we0 = 1'b0; od0 = 8'h00; end
    else     begin addr2 = IDLE_ADDR; we2 = 1'b0; od2 = 8'h00; end
  endtask

  // Issue an access whose expectations are already queued, then pop and compare.
  task automatic run_and_score(input string name, input bit sel,
                               input logic [15:0] a, input bit w,
                               input logic [7:0] d);
    int cyc, oe_lo, we_lo;
    logic [7:0] rd;
    bit stable, ff_ok;
    exp_t e;
    bus_access(sel, a, w, d, cyc, rd, oe_lo, we_lo, stable, ff_ok);
    e = sb.pop_front();
    checks++;
    if (cyc !== e.cycles) begin
      errors++; $display("FAIL %s_cycles got %0d want %0d", name, cyc, e.cycles);
    end
    if (e.chk_data) begin
      checks++;
      if (rd !== e.data) begin
        errors++; $display("FAIL %s_data got %h want %h", name, rd, e.data);
      end
    end
    checks++;
    if (oe_lo !== e.oe_lo || we_lo !== e.we_lo) begin
      errors++;
      $display("FAIL %s_strobes got oe_lo=%0d we_lo=%0d want oe_lo=%0d we_lo=%0d",
               name, oe_lo, we_lo, e.oe_lo, e.we_lo);
    end
    checks++;
    if (!stable || !ff_ok) begin
      errors++;
      $display("FAIL %s_stability got stable=%0d idata_ff=%0d want 1 1", name, stable, ff_ok);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    addr2 = IDLE_ADDR; we2 = 1'b0; od2 = 8'h00;
    addr0 = IDLE_ADDR; we0 = 1'b0; od0 = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (locked2 !== 1'b1 || id2 !== 8'hFF) begin
      errors++; $display("FAIL rst_io_locked got locked=%b i_data=%h want 1 ff", locked2, id2);
    end
    checks++;
    if (swe2 !== 1'b1 || soe2 !== 1'b1) begin
      errors++; $display("FAIL rst_strobes got we_n=%b oe_n=%b want 1 1", swe2, soe2);
    end
    checks++;
    if (sa2 !== 16'h0000 || sdo2 !== 8'h00 || leds2 !== 8'h00) begin
      errors++; $display("FAIL rst_regs got a=%h d=%h leds=%h want 0000 00 00", sa2, sdo2, leds2);
    end
    addr2 = 16'h1234;
    #1;
    checks++;
    if (locked2 !== 1'b0 || id2 !== 8'hFF) begin
      errors++; $display("FAIL rst_sram_locked got locked=%b i_data=%h want 0 ff", locked2, id2);
    end
    addr2 = IDLE_ADDR;
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic test_sram_read();
    sb.push_back('{chk_data: 1'b1, data: 8'h5A, cycles: 5, oe_lo: 3, we_lo: 0});
    run_and_score("rd1234", 1'b0, 16'h1234, 1'b0, 8'h00);
  endtask

  task automatic test_sram_write();
    sb.push_back('{chk_data: 1'b0, data: 8'h00, cycles: 5, oe_lo: 0, we_lo: 3});
    run_and_score("wr0010", 1'b0, 16'h0010, 1'b1, 8'hC3);
    sb.push_back('{chk_data: 1'b1, data: 8'hC3, cycles: 5, oe_lo: 3, we_lo: 0});
    run_and_score("rd0010", 1'b0, 16'h0010, 1'b0, 8'h00);
  endtask

  task automatic test_leds();
    sb.push_back('{chk_data: 1'b0, data: 8'h00, cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("wrff00", 1'b0, 16'hFF00, 1'b1, 8'hA5);
    checks++;
    if (leds2 !== 8'hA5) begin
      errors++; $display("FAIL leds_after_write got %h want a5", leds2);
    end
    sb.push_back('{chk_data: 1'b1, data: 8'hA5, cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("rdff00", 1'b0, 16'hFF00, 1'b0, 8'h00);
    // Writes outside the LED register leave it alone
    sb.push_back('{chk_data: 1'b0, data: 8'h00, cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("wrff01", 1'b0, 16'hFF01, 1'b1, 8'h77);
    sb.push_back('{chk_data: 1'b0, data: 8'h00, cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("wrff80", 1'b0, 16'hFF80, 1'b1, 8'h3C);
    checks++;
    if (leds2 !== 8'hA5) begin
      errors++; $display("FAIL leds_untouched got %h want a5", leds2);
    end
    sb.push_back('{chk_data: 1'b1, data: 8'hFF, cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("rdff80", 1'b0, 16'hFF80, 1'b0, 8'h00);
  endtask

  task automatic test_timer();
    int guard = 0;
    while (tb_timer !== 16'h12FF && guard < 70000) begin
      @(posedge clock); #1;
      guard++;
    end
    checks++;
    if (tb_timer !== 16'h12FF) begin
      errors++; $display("FAIL timer_reach got %h want 12ff", tb_timer);
    end
    sb.push_back('{chk_data: 1'b1, data: 8'hFF, cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("rdff01", 1'b0, 16'hFF01, 1'b0, 8'h00);
    repeat (3) @(posedge clock);
    #1;
    sb.push_back('{chk_data: 1'b0, data: 8'h00, cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("wrff02", 1'b0, 16'hFF02, 1'b1, 8'h33);
    sb.push_back('{chk_data: 1'b1, data: 8'h12, cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("rdff02", 1'b0, 16'hFF02, 1'b0, 8'h00);
    // Low byte tracks the live timer
    sb.push_back('{chk_data: 1'b1, data: tb_timer[7:0], cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("rdff01_live", 1'b0, 16'hFF01, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_run();
    sb.push_back('{chk_data: 1'b0, data: 8'h00, cycles: 1, oe_lo: 0, we_lo: 0});
    run_and_score("wrff00_b", 1'b0, 16'hFF00, 1'b1, 8'h5A);
    checks++;
    if (leds2 !== 8'h5A) begin
      errors++; $display("FAIL leds_pre_reset got %h want 5a", leds2);
    end
    tb_sel = 1'b0;
    addr2 = 16'h0020; we2 = 1'b1; od2 = 8'h99;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (swe2 !== 1'b0) begin
      errors++; $display("FAIL midrun_we_low got %b want 0", swe2);
    end
    #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (swe2 !== 1'b1 || soe2 !== 1'b1) begin
      errors++; $display("FAIL abort_strobes got we_n=%b oe_n=%b want 1 1", swe2, soe2);
    end
    checks++;
    if (leds2 !== 8'h00) begin
      errors++; $display("FAIL abort_leds got %h want 00", leds2);
    end
    addr2 = IDLE_ADDR; we2 = 1'b0; od2 = 8'h00;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (locked2 !== 1'b1) begin
      errors++; $display("FAIL abort_idle got locked=%b want 1", locked2);
    end
    @(posedge clock); #1;
    sb.push_back('{chk_data: 1'b1, data: 8'h5A, cycles: 5, oe_lo: 3, we_lo: 0});
    run_and_score("rd1234_after_abort", 1'b0, 16'h1234, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{chk_data: 1'b1, data: 8'h3C, cycles: 3, oe_lo: 1, we_lo: 0});
    end
    for (int i = 0; i < 3; i++) begin
      run_and_score($sformatf("b2b%0d", i), 1'b1, 16'h4321, 1'b0, 8'h00);
    end
    sb.push_back('{chk_data: 1'b0, data: 8'h00, cycles: 3, oe_lo: 0, we_lo: 1});
    run_and_score("b2b_wr", 1'b1, 16'h4321, 1'b1, 8'h81);
    sb.push_back('{chk_data: 1'b1, data: 8'h81, cycles: 3, oe_lo: 1, we_lo: 0});
    run_and_score("b2b_rd", 1'b1, 16'h4321, 1'b0, 8'h00);
  endtask

  initial begin
    mem2[16'h1234] = 8'h5A;
    mem0[16'h4321] = 8'h3C;
    tb_sel = 1'b0;
    test_reset();
    test_sram_read();
    test_sram_write();
    test_leds();
    test_timer();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
